tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Receive-side counterpart of the 4-to-1 selector: a time-division demultiplexer that takes one 4-bit serial word stream, tracks slot position from a start-of-frame marker and distributes slots 0..3 to four registered 4-bit outputs. The block sits at the far end of a TDM link whose transmit side walks the selector through `{iS1,iS0}` = 00, 01, 10, 11. It publishes each complete frame atomically and flags sync errors. Frames are only ever published whole, never partially.

## Interface
- No parameters; data width is fixed at 4 bits and the slot count at 4.
- iClk  in  1  rising-edge clock
- iRst_n  in  1  asynchronous, active-low reset
- iZ  in  4  incoming slot word
- iValid  in  1  iZ carries a word this cycle
- iSof  in  1  qualifies iZ as slot 0 of a frame; ignored when iValid=0
- oC0, oC1, oC2, oC3  out  4 each  published slot 0..3 data of the last good frame
- oFrameValid  out  1  one-cycle pulse: oC0..oC3 just updated
- oSyncErr  out  1  one-cycle pulse: SOF arrived mid-frame
- oS1, oS0  out  1 each  index of the next expected slot

## Operation
- State machine with two states:
  - HUNT: reset state, waiting for SOF.
  - RECV: collecting slots 1..3.
- Shadow registers sh0..sh3 hold the words of the frame in progress. The slot counter `{oS1,oS0}` is 2 bits.
- HUNT:
  - iValid & iSof: sh0←iZ, slot←01, go to RECV.
  - iValid & !iSof: word discarded, no flag.
  - iValid=0: hold.
- RECV:
  - iValid=0: hold all state (stall is unlimited).
  - iValid & !iSof, slot≠11: sh[slot]←iZ, slot←slot+1.
  - iValid & !iSof, slot=11: oC0..oC3←{sh0,sh1,sh2,iZ} in the same edge, oFrameValid=1, slot←00, go to HUNT.
  - iValid & iSof: oSyncErr=1, partial frame dropped, sh0←iZ, slot←01, stay in RECV (resync on the new SOF).
- oC0..oC3 change only on frame publication. They hold their value otherwise, including through errors.
- Frames need not be back-to-back. SOF may arrive in the cycle directly after publication.

## Timing
- All outputs are registered.
- Reset values: oC0..oC3=0000, oFrameValid=0, oSyncErr=0, `{oS1,oS0}`=00, state=HUNT, sh0..sh3=0000.
- Latency: oC0..oC3 and oFrameValid become visible one cycle after the clock edge that samples the slot-3 word.
- With no stalls, the publication pulse comes 4 cycles after SOF is sampled.
- oFrameValid and oSyncErr are single-cycle pulses and are never asserted in the same cycle.
- Reset mid-frame: everything returns to reset values immediately (asynchronously). The partial frame is lost and no pulse is generated.
- The first edge after iRst_n deasserts behaves as HUNT.
- Slot counter wrap from 11 to 00 occurs only on publication.

## Configuration
- Macro: `TDM_DEMUX4_PARITY_EN`.
- Defined:
  - Adds input iPar (1 bit) and output oParErr (1-cycle pulse).
  - Each accepted word must satisfy ^{iPar,iZ}=1 (odd parity). A failure sets a sticky frame-bad bit.
  - On slot-3 acceptance of a bad frame: no publication, oFrameValid=0, oParErr=1, return to HUNT, frame-bad bit cleared.
  - A SOF resync also clears the frame-bad bit, then checks the SOF word itself.
  - Reset value of oParErr is 0.
- Undefined: no iPar or oParErr ports and no checking; every complete frame is published.

## Test plan
- Reset and steady publication:
  - Stimulus: reset, then consecutive words 1111(SOF), 0111, 0011, 0001.
  - Required: oC0..oC3 = 1111/0111/0011/0001 with one oFrameValid pulse one cycle after the last word; `{oS1,oS0}` steps 01, 10, 11, 00.
- Stall tolerance:
  - Stimulus: the same frame with iValid=0 for 3 cycles between slots 1 and 2.
  - Required: identical outputs, with the pulse delayed by 3 cycles; oC unchanged during the stall.
- HUNT filtering:
  - Stimulus: 0011 and 0001 without SOF, then frame 0000, 0000, 1111(slot 2), 0000.
  - Required: the first two words are ignored; oC2=1111 and all others 0000.
- Premature SOF:
  - Stimulus: 1111(SOF), 0111, 0000(SOF), 0000, 0000, 1111.
  - Required: oSyncErr pulses once; the published frame is 0000/0000/0000/1111; the previous oC values are held until then.
- Reset mid-frame:
  - Stimulus: iRst_n low after slot 2 of a frame.
  - Required: oC=0000 and `{oS1,oS0}`=00 immediately; no pulse; a subsequent SOF frame publishes normally.
- Parity (with `TDM_DEMUX4_PARITY_EN` defined):
  - Stimulus: a frame with wrong iPar on slot 1.
  - Required: oParErr pulses once, no oFrameValid, oC retains its previous values.

Source files
------------

// File: rtl/tdm_demux4_if.sv
// Bus bundle for the tdm_demux4 receive-side TDM demultiplexer.
// Optional parity signals appear only when TDM_DEMUX4_PARITY_EN is defined.
interface tdm_demux4_if;
   logic [3:0] iZ;
   logic       iValid;
   logic       iSof;
   logic [3:0] oC0;
   logic [3:0] oC1;
   logic [3:0] oC2;
   logic [3:0] oC3;
   logic       oFrameValid;
   logic       oSyncErr;
   logic       oS1;
   logic       oS0;
`ifdef TDM_DEMUX4_PARITY_EN
   logic       iPar;
   logic       oParErr;

   modport master (
      output iZ, iValid, iSof, iPar,
      input  oC0, oC1, oC2, oC3, oFrameValid, oSyncErr, oS1, oS0, oParErr
   );

   modport slave (
      input  iZ, iValid, iSof, iPar,
      output oC0, oC1, oC2, oC3, oFrameValid, oSyncErr, oS1, oS0, oParErr
   );
`else
   modport master (
      output iZ, iValid, iSof,
      input  oC0, oC1, oC2, oC3, oFrameValid, oSyncErr, oS1, oS0
   );

   modport slave (
      input  iZ, iValid, iSof,
      output oC0, oC1, oC2, oC3, oFrameValid, oSyncErr, oS1, oS0
   );
`endif
endinterface

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: tracks slot position from SOF and publishes whole frames atomically.
// Optional odd-parity checking is enabled by defining TDM_DEMUX4_PARITY_EN.
module tdm_demux4 (
   input  logic           iClk,
   input  logic           iRst_n,
   tdm_demux4_if.slave    bus
);

   typedef enum logic {
      HUNT = 1'b0,
      RECV = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] slot_q, slot_d;
   logic [3:0] sh0_q, sh0_d;
   logic [3:0] sh1_q, sh1_d;
   logic [3:0] sh2_q, sh2_d;
   logic [3:0] c0_q, c0_d;
   logic [3:0] c1_q, c1_d;
   logic [3:0] c2_q, c2_d;
   logic [3:0] c3_q, c3_d;
   logic       frame_valid_q, frame_valid_d;
   logic       sync_err_q, sync_err_d;

   logic       sof_word;
   logic       data_word;
   logic       last_slot;
   logic       frame_reject;

   assign sof_word  = bus.iValid & bus.iSof;
   assign data_word = bus.iValid & ~bus.iSof;
   assign last_slot = (slot_q == 2'b11);

`ifdef TDM_DEMUX4_PARITY_EN
   logic frame_bad_q, frame_bad_d;
   logic par_err_q, par_err_d;
   logic word_bad;

   assign word_bad     = ~(^{bus.iPar, bus.iZ});
   assign frame_reject = frame_bad_q | word_bad;

   // A SOF always restarts the bad-frame tracking from the SOF word itself.
   always_comb begin
      frame_bad_d = frame_bad_q;
      par_err_d   = 1'b0;
      if (sof_word) begin
         frame_bad_d = word_bad;
      end else if (data_word && state_q == RECV) begin
         if (last_slot) begin
            frame_bad_d = 1'b0;
            par_err_d   = frame_bad_q | word_bad;
         end else begin
            frame_bad_d = frame_bad_q | word_bad;
         end
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         frame_bad_q <= 1'b0;
         par_err_q   <= 1'b0;
      end else begin
         frame_bad_q <= frame_bad_d;
         par_err_q   <= par_err_d;
      end
   end

   assign bus.oParErr = par_err_q;
`else
   assign frame_reject = 1'b0;
`endif

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HUNT: begin
            if (sof_word) begin
               state_d = RECV;
            end
         end
         RECV: begin
            if (data_word && last_slot) begin
               state_d = HUNT;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // The slot-3 word bypasses the shadow registers straight into the outputs.
   always_comb begin
      slot_d        = slot_q;
      sh0_d         = sh0_q;
      sh1_d         = sh1_q;
      sh2_d         = sh2_q;
      c0_d          = c0_q;
      c1_d          = c1_q;
      c2_d          = c2_q;
      c3_d          = c3_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;
      case (state_q)
         HUNT: begin
            if (sof_word) begin
               sh0_d  = bus.iZ;
               slot_d = 2'b01;
            end
         end
         RECV: begin
            if (sof_word) begin
               sync_err_d = 1'b1;
               sh0_d      = bus.iZ;
               slot_d     = 2'b01;
            end else if (data_word) begin
               if (last_slot) begin
                  slot_d = 2'b00;
                  if (!frame_reject) begin
                     c0_d          = sh0_q;
                     c1_d          = sh1_q;
                     c2_d          = sh2_q;
                     c3_d          = bus.iZ;
                     frame_valid_d = 1'b1;
                  end
               end else begin
                  case (slot_q)
                     2'b01:   sh1_d = bus.iZ;
                     2'b10:   sh2_d = bus.iZ;
                     default: sh0_d = sh0_q;
                  endcase
                  slot_d = slot_q + 2'b01;
               end
            end
         end
         default: slot_d = 2'b00;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         slot_q        <= 2'b00;
         sh0_q         <= 4'b0000;
         sh1_q         <= 4'b0000;
         sh2_q         <= 4'b0000;
         c0_q          <= 4'b0000;
         c1_q          <= 4'b0000;
         c2_q          <= 4'b0000;
         c3_q          <= 4'b0000;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         slot_q        <= slot_d;
         sh0_q         <= sh0_d;
         sh1_q         <= sh1_d;
         sh2_q         <= sh2_d;
         c0_q          <= c0_d;
         c1_q          <= c1_d;
         c2_q          <= c2_d;
         c3_q          <= c3_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign bus.oC0         = c0_q;
   assign bus.oC1         = c1_q;
   assign bus.oC2         = c2_q;
   assign bus.oC3         = c3_q;
   assign bus.oFrameValid = frame_valid_q;
   assign bus.oSyncErr    = sync_err_q;
   assign bus.oS1         = slot_q[1];
   assign bus.oS0         = slot_q[0];

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: a frame-level model queues expected pulses, a monitor checks them.
// Build with TDM_DEMUX4_PARITY_EN defined to exercise the parity option.
module tb_tdm_demux4;

`ifdef TDM_DEMUX4_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct {
      int          kind;
      logic [15:0] data;
   } ev_t;

   logic iClk = 1'b0;
   logic iRst_n;

   tdm_demux4_if bus();

   tdm_demux4 dut (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .bus    (bus)
   );

   always #5 iClk = ~iClk;

   ev_t         evQ[$];
   logic [3:0]  partial[$];
   bit          frameBad;
   int          expSlot;
   logic [15:0] lastPub;
   int          compared;
   int          mismatched;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Frame-level reference: a frame is the SOF word plus the next three accepted words.
   task automatic modelUpdate(input logic v, input logic s, input logic [3:0] z, input bit parWrong);
      bit wb;
      ev_t e;
      wb = PAR_EN && parWrong;
      if (v) begin
         if (s) begin
            if (partial.size() != 0) begin
               e.kind = 1; e.data = 16'h0;
               evQ.push_back(e);
            end
            partial.delete();
            partial.push_back(z);
            frameBad = wb;
         end else if (partial.size() != 0) begin
            partial.push_back(z);
            frameBad = frameBad || wb;
            if (partial.size() == 4) begin
               e.kind = frameBad ? 2 : 0;
               e.data = frameBad ? 16'h0 : {partial[0], partial[1], partial[2], partial[3]};
               evQ.push_back(e);
               partial.delete();
               frameBad = 1'b0;
            end
         end
      end
      expSlot = partial.size();
   endtask

   task automatic applyStimulus(input logic v, input logic s, input logic [3:0] z, input bit parWrong);
      @(negedge iClk);
      bus.iValid = v;
      bus.iSof   = s;
      bus.iZ     = z;
`ifdef TDM_DEMUX4_PARITY_EN
      bus.iPar   = (~(^z)) ^ parWrong;
`endif
      @(posedge iClk);
      #1;
      modelUpdate(v, s, z, parWrong);
   endtask

   task automatic resetMidFrame();
      @(negedge iClk);
      bus.iValid = 1'b0;
      bus.iSof   = 1'b0;
      #2;
      iRst_n = 1'b0;
      #1;
      checkOutput("rst_async_oc", {bus.oC0, bus.oC1, bus.oC2, bus.oC3}, 16'h0000);
      checkOutput("rst_async_slot", {bus.oS1, bus.oS0}, 2'b00);
      checkOutput("rst_async_fv", bus.oFrameValid, 1'b0);
      partial.delete();
      frameBad = 1'b0;
      expSlot  = 0;
      lastPub  = 16'h0;
      @(negedge iClk);
      @(negedge iClk);
      #2;
      iRst_n = 1'b1;
   endtask

   // Monitor: pops one expected event whenever the DUT pulses, and checks held outputs every cycle.
   always @(negedge iClk) begin : monitor
      int   pulses;
      int   actKind;
      ev_t  e;
      if (!iRst_n) begin
         lastPub = 16'h0;
      end else begin
         checkOutput("slot", {bus.oS1, bus.oS0}, expSlot[1:0]);
         pulses  = int'(bus.oFrameValid) + int'(bus.oSyncErr);
         actKind = bus.oFrameValid ? 0 : 1;
`ifdef TDM_DEMUX4_PARITY_EN
         pulses = pulses + int'(bus.oParErr);
         if (bus.oParErr && !bus.oFrameValid && !bus.oSyncErr) actKind = 2;
`endif
         if (pulses != 0 || evQ.size() != 0) begin
            checkOutput("pulse_count", pulses, (evQ.size() != 0) ? 1 : 0);
            if (evQ.size() != 0) begin
               e = evQ.pop_front();
               if (pulses == 1) begin
                  checkOutput("event_kind", actKind, e.kind);
                  if (e.kind == 0) begin
                     checkOutput("frame_data", {bus.oC0, bus.oC1, bus.oC2, bus.oC3}, e.data);
                  end
               end
               if (e.kind == 0) lastPub = e.data;
            end
         end
         checkOutput("oc_hold", {bus.oC0, bus.oC1, bus.oC2, bus.oC3}, lastPub);
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      expSlot    = 0;
      frameBad   = 1'b0;
      lastPub    = 16'h0;
      iRst_n     = 1'b0;
      bus.iValid = 1'b0;
      bus.iSof   = 1'b0;
      bus.iZ     = 4'h0;
`ifdef TDM_DEMUX4_PARITY_EN
      bus.iPar   = 1'b0;
`endif
      #3;
      checkOutput("reset_oc", {bus.oC0, bus.oC1, bus.oC2, bus.oC3}, 16'h0000);
      checkOutput("reset_slot", {bus.oS1, bus.oS0}, 2'b00);
      checkOutput("reset_pulses", {bus.oFrameValid, bus.oSyncErr}, 2'b00);
      #9;
      iRst_n = 1'b1;

      // Steady publication
      applyStimulus(1, 1, 4'hF, 0);
      checkOutput("tp1_slot1", {bus.oS1, bus.oS0}, 2'b01);
      applyStimulus(1, 0, 4'h7, 0);
      checkOutput("tp1_slot2", {bus.oS1, bus.oS0}, 2'b10);
      applyStimulus(1, 0, 4'h3, 0);
      checkOutput("tp1_slot3", {bus.oS1, bus.oS0}, 2'b11);
      applyStimulus(1, 0, 4'h1, 0);
      checkOutput("tp1_oc", {bus.oC0, bus.oC1, bus.oC2, bus.oC3}, 16'hF731);
      checkOutput("tp1_fv", bus.oFrameValid, 1'b1);
      checkOutput("tp1_wrap", {bus.oS1, bus.oS0}, 2'b00);
      applyStimulus(0, 0, 4'h0, 0);
      checkOutput("tp1_fv_single", bus.oFrameValid, 1'b0);

      // Stall tolerance
      applyStimulus(1, 1, 4'hF, 0);
      applyStimulus(1, 0, 4'h7, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'($urandom), 0);
      checkOutput("tp2_stall_fv", bus.oFrameValid, 1'b0);
      applyStimulus(1, 0, 4'h3, 0);
      applyStimulus(1, 0, 4'h1, 0);
      checkOutput("tp2_oc", {bus.oC0, bus.oC1, bus.oC2, bus.oC3}, 16'hF731);

      // HUNT filtering
      applyStimulus(1, 0, 4'h3, 0);
      applyStimulus(1, 0, 4'h1, 0);
      applyStimulus(1, 1, 4'h0, 0);
      applyStimulus(1, 0, 4'h0, 0);
      applyStimulus(1, 0, 4'hF, 0);
      applyStimulus(1, 0, 4'h0, 0);
      checkOutput("tp3_oc", {bus.oC0, bus.oC1, bus.oC2, bus.oC3}, 16'h00F0);

      // Premature SOF
      applyStimulus(1, 1, 4'hF, 0);
      applyStimulus(1, 0, 4'h7, 0);
      applyStimulus(1, 1, 4'h0, 0);
      checkOutput("tp4_syncerr", bus.oSyncErr, 1'b1);
      checkOutput("tp4_held", {bus.oC0, bus.oC1, bus.oC2, bus.oC3}, 16'h00F0);
      applyStimulus(1, 0, 4'h0, 0);
      applyStimulus(1, 0, 4'h0, 0);
      applyStimulus(1, 0, 4'hF, 0);
      checkOutput("tp4_oc", {bus.oC0, bus.oC1, bus.oC2, bus.oC3}, 16'h000F);

      // Reset mid-frame, then a normal frame
      applyStimulus(1, 1, 4'hF, 0);
      applyStimulus(1, 0, 4'h7, 0);
      applyStimulus(1, 0, 4'h3, 0);
      resetMidFrame();
      applyStimulus(1, 1, 4'h1, 0);
      applyStimulus(1, 0, 4'h2, 0);
      applyStimulus(1, 0, 4'h3, 0);
      applyStimulus(1, 0, 4'h4, 0);
      checkOutput("tp5_oc", {bus.oC0, bus.oC1, bus.oC2, bus.oC3}, 16'h1234);

`ifdef TDM_DEMUX4_PARITY_EN
      // Wrong parity on slot 1 suppresses publication
      applyStimulus(1, 1, 4'h5, 0);
      applyStimulus(1, 0, 4'h6, 1);
      applyStimulus(1, 0, 4'h7, 0);
      applyStimulus(1, 0, 4'h8, 0);
      checkOutput("tp6_parerr", bus.oParErr, 1'b1);
      checkOutput("tp6_fv", bus.oFrameValid, 1'b0);
      checkOutput("tp6_oc", {bus.oC0, bus.oC1, bus.oC2, bus.oC3}, 16'h1234);
`endif

      // Back-to-back frames: SOF right after publication
      for (int f = 0; f < 3; f++) begin
         applyStimulus(1, 1, 4'($urandom), 0);
         for (int k = 0; k < 3; k++) applyStimulus(1, 0, 4'($urandom), 0);
      end

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         applyStimulus(($urandom % 4) != 0, ($urandom % 6) == 0, 4'($urandom), ($urandom % 12) == 0);
      end

      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 4'h0, 0);
      checkOutput("queue_drained", evQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
